ram_pkt_writer: RTL and testbench
=================================

RAM_PKT_WRITER -- requirements
Module: ram_pkt_writer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: s_axis_pkt_valid in 1, s_axis_pkt_ready out 1, s_axis_pkt_data in 528, s_axis_pkt_last in 1; this is the packet input, 64B payload per beat.
REQ-004 SHALL have port s_axis_pkt_len  in  10; it carries the packet byte length and is valid with the first beat only.
REQ-005 SHALL have ports: m_ram_valid out 1, m_ram_data out 528, m_ram_ready in 1, m_ram_addr out 16, m_ram_rw out 1; these drive one ram write port.
REQ-006 SHALL have ports: m_desc_valid out 1, m_desc_ready in 1, m_desc_addr out 16, m_desc_len out 10; these form the stored-packet descriptor output.
REQ-007 SHALL have ports: s_free_valid in 1, s_free_class in 2; a pulse returns one slot of that class.
REQ-008 SHALL have ports: drop_cnt out 16 (dropped packets) and free_ovf out 1 (sticky flag for a release to a full class).

Function
REQ-009 SHALL select the class from len:
  - 1..64 gives class 0.
  - 65..128 gives class 1.
  - 129..256 gives class 2.
  - 257..512 gives class 3.
  - 0 or >512 means the packet is dropped.
REQ-010 SHALL use region base {class,14'b0} and slot size 2^class beats; each class keeps a 14-bit offset pointer wrapping mod 2^14 and a 15-bit free-slot count, reset to 16384>>class.
REQ-011 SHALL compute data beats as ceil(len/64) and total beats as 2^class; m_ram_addr = {class, offset} on every beat of the packet, and m_ram_rw = 1 constantly.
REQ-012 SHALL implement the FSM states IDLE, WAIT_SLOT, WRITE, PAD, DROP, DESC.
REQ-013 IDLE SHALL sample len and class on the first beat without accepting it (s_axis_pkt_ready=0):
  - drop class goes to DROP;
  - a free count of 0 goes to WAIT_SLOT;
  - otherwise the state SHALL allocate (count-1, latch offset) and go to WRITE.
REQ-014 WAIT_SLOT SHALL hold s_axis_pkt_ready=0 until the class count is >0, then allocate and go to WRITE.
REQ-015 WRITE SHALL accept beats only when m_ram output register is empty or m_ram_ready=1, registering data into m_ram_data/m_ram_valid, with 1-cycle latency input to output.
REQ-016 WRITE SHALL count accepted beats:
  - When the data-beat count is reached without last, later beats SHALL be consumed and discarded until last.
  - When last arrives early, the remaining beats SHALL be zero-filled.
  - Either way it then goes to PAD, or to DESC if the total is already reached.
REQ-017 PAD SHALL emit zero data beats, with s_axis_pkt_ready=0, until exactly 2^class beats total have been sent to ram.
REQ-018 After the final ram beat handshake, the block SHALL go to DESC:
  - m_desc_valid=1, m_desc_addr = slot addr, m_desc_len = len.
  - m_desc_valid is held until m_desc_ready, then the block returns to IDLE.
  - offset SHALL advance by 2^class at allocation.
REQ-019 DROP SHALL consume beats with s_axis_pkt_ready=1 until last, increment drop_cnt (saturating at 0xFFFF), write nothing to ram, and return to IDLE.
REQ-020 m_ram_valid SHALL stay asserted with stable data/addr until m_ram_ready.
REQ-021 A free pulse SHALL increment the class count:
  - at count = max, the count is unchanged and free_ovf is set;
  - free and allocation of the same class in one cycle leave the count unchanged.
REQ-022 Releases per class SHALL be in allocation order; the block does not track slot identity.

Reset
REQ-023 On rst_n=0 the block SHALL clear all outputs: valid/ready=0, data/addr/len=0, m_ram_rw=0, drop_cnt=0, free_ovf=0.
REQ-024 On reset the FSM SHALL go to IDLE, offsets=0, and counts SHALL reset to 16384/8192/4096/2048.
REQ-025 Reset mid-packet SHALL abandon the packet with no descriptor; after release m_ram_rw=1 from the first active cycle.

Verification
REQ-026 60-byte packet, 1 beat, ram always ready -> 1 ram beat at addr 0x0000, then desc addr 0x0000 len 60; class0 count becomes 16383.
REQ-027 300-byte packet, 5 beats -> 5 data beats + 3 zero beats at addr 0xC000; next class3 packet gets addr 0xC008.
REQ-028 Packet with len 0 or 600 -> no ram traffic, no desc, drop_cnt = 1, and all input beats consumed.
REQ-029 Class1 count exhausted to 0 -> the next 100-byte packet stalls in WAIT_SLOT; one s_free_valid class1 -> it writes 2 beats.
REQ-030 m_ram_ready toggled randomly and m_desc_ready held low -> no beat lost or duplicated, and no new packet accepted until the desc is taken.
REQ-031 Free to class2 at full count -> count stays 4096 and free_ovf=1; reset asserted mid-WRITE -> all outputs 0, counts restored.

Source files
------------

// File: rtl/ram_pkt_writer.sv
// Packet-to-RAM writer: allocates a power-of-two slot per size class, writes the packet padded
// to the slot size through one ram write port, then emits a descriptor for the stored packet.
module ram_pkt_writer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_axis_pkt_valid,
    output logic         s_axis_pkt_ready,
    input  logic [527:0] s_axis_pkt_data,
    input  logic         s_axis_pkt_last,
    input  logic [9:0]   s_axis_pkt_len,
    output logic         m_ram_valid,
    output logic [527:0] m_ram_data,
    input  logic         m_ram_ready,
    output logic [15:0]  m_ram_addr,
    output logic         m_ram_rw,
    output logic         m_desc_valid,
    input  logic         m_desc_ready,
    output logic [15:0]  m_desc_addr,
    output logic [9:0]   m_desc_len,
    input  logic         s_free_valid,
    input  logic [1:0]   s_free_class,
    output logic [15:0]  drop_cnt,
    output logic         free_ovf
);
    typedef enum logic [2:0] {StIdle, StWaitSlot, StWrite, StPad, StDrop, StDesc} state_e;

    localparam logic [3:0][14:0] CountMax = {15'd2048, 15'd4096, 15'd8192, 15'd16384};

    state_e           state_q;
    logic [1:0]       cls_q;
    logic [9:0]       len_q;
    logic [3:0]       data_beats_q;
    logic [3:0]       beat_q;
    logic [3:0][13:0] offset_q;
    logic [3:0][14:0] count_q;

    logic       len_ok;
    logic [1:0] len_cls;
    logic       out_free;
    logic       in_fire;
    logic       alloc;
    logic [1:0] alloc_cls;
    logic [3:0] total;
    logic [3:0] inc;
    logic [3:0] dec;

    always_comb begin
        len_ok  = 1'b1;
        len_cls = 2'd0;
        if (s_axis_pkt_len == 10'd0 || s_axis_pkt_len > 10'd512) len_ok = 1'b0;
        else if (s_axis_pkt_len > 10'd256) len_cls = 2'd3;
        else if (s_axis_pkt_len > 10'd128) len_cls = 2'd2;
        else if (s_axis_pkt_len > 10'd64)  len_cls = 2'd1;
    end

    assign out_free = !m_ram_valid || m_ram_ready;
    assign in_fire  = s_axis_pkt_valid && s_axis_pkt_ready;
    assign total    = 4'd1 << cls_q;

    always_comb begin
        alloc            = 1'b0;
        alloc_cls        = len_cls;
        s_axis_pkt_ready = 1'b0;
        case (state_q)
            StIdle:     alloc = s_axis_pkt_valid && len_ok && (count_q[len_cls] != 15'd0);
            StWaitSlot: begin
                alloc_cls = cls_q;
                alloc     = count_q[cls_q] != 15'd0;
            end
            // Beats past the data-beat count are swallowed regardless of the ram port.
            StWrite:    s_axis_pkt_ready = (beat_q < data_beats_q) ? out_free : 1'b1;
            StDrop:     s_axis_pkt_ready = 1'b1;
            default:    s_axis_pkt_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cls_q        <= 2'd0;
            len_q        <= 10'd0;
            data_beats_q <= 4'd0;
            beat_q       <= 4'd0;
            offset_q     <= '0;
            m_ram_valid  <= 1'b0;
            m_ram_data   <= '0;
            m_ram_addr   <= 16'd0;
            m_ram_rw     <= 1'b0;
            m_desc_valid <= 1'b0;
            m_desc_addr  <= 16'd0;
            m_desc_len   <= 10'd0;
            drop_cnt     <= 16'd0;
        end else begin
            m_ram_rw <= 1'b1;
            if (m_ram_ready) m_ram_valid <= 1'b0;
            if (alloc) begin
                offset_q[alloc_cls] <= offset_q[alloc_cls] + (14'd1 << alloc_cls);
                m_ram_addr          <= {alloc_cls, offset_q[alloc_cls]};
                beat_q              <= 4'd0;
                state_q             <= StWrite;
            end
            case (state_q)
                StIdle: begin
                    if (s_axis_pkt_valid) begin
                        cls_q        <= len_cls;
                        len_q        <= s_axis_pkt_len;
                        data_beats_q <= 4'(({1'b0, s_axis_pkt_len} + 11'd63) >> 6);
                        if (!len_ok)     state_q <= StDrop;
                        else if (!alloc) state_q <= StWaitSlot;
                    end
                end
                StWaitSlot: begin
                end
                StWrite: begin
                    if (in_fire) begin
                        if (beat_q < data_beats_q) begin
                            m_ram_valid <= 1'b1;
                            m_ram_data  <= s_axis_pkt_data;
                            beat_q      <= beat_q + 4'd1;
                        end
                        if (s_axis_pkt_last) state_q <= StPad;
                    end
                end
                // Zero-fill to the slot size, then wait for the last beat to drain.
                StPad: begin
                    if (out_free) begin
                        if (beat_q < total) begin
                            m_ram_valid <= 1'b1;
                            m_ram_data  <= '0;
                            beat_q      <= beat_q + 4'd1;
                        end else begin
                            m_desc_valid <= 1'b1;
                            m_desc_addr  <= m_ram_addr;
                            m_desc_len   <= len_q;
                            state_q      <= StDesc;
                        end
                    end
                end
                StDesc: begin
                    if (m_desc_ready) begin
                        m_desc_valid <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                StDrop: begin
                    if (in_fire && s_axis_pkt_last) begin
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            inc[i] = s_free_valid && (s_free_class == 2'(i));
            dec[i] = alloc && (alloc_cls == 2'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) count_q[i] <= CountMax[i];
            free_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dec[i] && !inc[i]) begin
                    count_q[i] <= count_q[i] - 15'd1;
                end else if (inc[i] && !dec[i]) begin
                    if (count_q[i] == CountMax[i]) free_ovf <= 1'b1;
                    else count_q[i] <= count_q[i] + 15'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_pkt_writer.sv
// Scoreboard bench for ram_pkt_writer: a slot-allocation model predicts every ram beat and
// descriptor; a monitor compares them whenever the DUT hands one over.
module tb_ram_pkt_writer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         s_axis_pkt_valid = 1'b0;
    logic         s_axis_pkt_ready;
    logic [527:0] s_axis_pkt_data = '0;
    logic         s_axis_pkt_last = 1'b0;
    logic [9:0]   s_axis_pkt_len = '0;
    logic         m_ram_valid;
    logic [527:0] m_ram_data;
    logic         m_ram_ready = 1'b1;
    logic [15:0]  m_ram_addr;
    logic         m_ram_rw;
    logic         m_desc_valid;
    logic         m_desc_ready = 1'b1;
    logic [15:0]  m_desc_addr;
    logic [9:0]   m_desc_len;
    logic         s_free_valid = 1'b0;
    logic [1:0]   s_free_class = '0;
    logic [15:0]  drop_cnt;
    logic         free_ovf;

    always #5 clk = ~clk;

    ram_pkt_writer dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_pkt_valid(s_axis_pkt_valid), .s_axis_pkt_ready(s_axis_pkt_ready),
        .s_axis_pkt_data(s_axis_pkt_data), .s_axis_pkt_last(s_axis_pkt_last),
        .s_axis_pkt_len(s_axis_pkt_len),
        .m_ram_valid(m_ram_valid), .m_ram_data(m_ram_data), .m_ram_ready(m_ram_ready),
        .m_ram_addr(m_ram_addr), .m_ram_rw(m_ram_rw),
        .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
        .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len),
        .s_free_valid(s_free_valid), .s_free_class(s_free_class),
        .drop_cnt(drop_cnt), .free_ovf(free_ovf)
    );

    typedef struct { logic [15:0] addr; logic [527:0] data; } ram_beat_t;
    typedef struct { logic [15:0] addr; logic [9:0] len; } desc_t;

    ram_beat_t ram_q[$];
    desc_t     desc_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-class next slot offset and free-slot count.
    int m_off[4];
    int m_cnt[4];
    int m_drop;
    bit m_ovf;
    bit ignore_mon = 1'b0;
    bit ram_rand = 1'b0;
    bit desc_rand = 1'b0;
    bit desc_hold = 1'b0;

    task automatic chk(input string name, input logic [559:0] act, input logic [559:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int info);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (%0d)", name, info);
    endtask

    function automatic logic [527:0] rand_beat();
        logic [543:0] r;
        for (int i = 0; i < 17; i++) r[i*32 +: 32] = $urandom;
        return r[527:0];
    endfunction

    function automatic int cls_of(input int len);
        if (len < 1 || len > 512) return -1;
        if (len <= 64) return 0;
        if (len <= 128) return 1;
        if (len <= 256) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_off[i] = 0;
            m_cnt[i] = 16384 >> i;
        end
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int nbeats);
        logic [527:0] beats[$];
        ram_beat_t    rb;
        desc_t        d;
        int           c, nd, slot, w;
        bit           abort;
        for (int i = 0; i < nbeats; i++) beats.push_back(rand_beat());
        c = cls_of(len);
        if (c < 0) begin
            m_drop++;
        end else begin
            slot    = 1 << c;
            nd      = (len + 63) / 64;
            rb.addr = {2'(c), 14'(m_off[c])};
            m_off[c] = (m_off[c] + slot) % 16384;
            if (m_cnt[c] > 0) m_cnt[c]--;
            for (int k = 0; k < slot; k++) begin
                rb.data = (k < nbeats && k < nd) ? beats[k] : '0;
                ram_q.push_back(rb);
            end
            d.addr = rb.addr;
            d.len  = 10'(len);
            desc_q.push_back(d);
        end
        abort = 1'b0;
        for (int i = 0; i < nbeats && !abort; i++) begin
            s_axis_pkt_valid = 1'b1;
            s_axis_pkt_data  = beats[i];
            s_axis_pkt_last  = (i == nbeats - 1);
            s_axis_pkt_len   = (i == 0) ? 10'(len) : 10'($urandom);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!s_axis_pkt_ready && w < 4000);
            if (!s_axis_pkt_ready) begin
                fail_now("beat_accept", len);
                abort = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        s_axis_pkt_valid = 1'b0;
        s_axis_pkt_last  = 1'b0;
    endtask

    task automatic free_pulse(input int c);
        s_free_valid = 1'b1;
        s_free_class = 2'(c);
        if (m_cnt[c] == (16384 >> c)) m_ovf = 1'b1;
        else m_cnt[c]++;
        @(posedge clk);
        #1;
        s_free_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((ram_q.size() != 0 || desc_q.size() != 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (ram_q.size() != 0 || desc_q.size() != 0) begin
            fail_now("drain", ram_q.size() + desc_q.size());
            ram_q.delete();
            desc_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_valid"}, 560'(m_ram_valid), 560'(0));
        chk({tag, "_ram_data"}, 560'(m_ram_data), 560'(0));
        chk({tag, "_ram_addr"}, 560'(m_ram_addr), 560'(0));
        chk({tag, "_ram_rw"}, 560'(m_ram_rw), 560'(0));
        chk({tag, "_pkt_ready"}, 560'(s_axis_pkt_ready), 560'(0));
        chk({tag, "_desc_valid"}, 560'(m_desc_valid), 560'(0));
        chk({tag, "_desc_addr"}, 560'(m_desc_addr), 560'(0));
        chk({tag, "_desc_len"}, 560'(m_desc_len), 560'(0));
        chk({tag, "_drop_cnt"}, 560'(drop_cnt), 560'(0));
        chk({tag, "_free_ovf"}, 560'(free_ovf), 560'(0));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ram_ready  = ram_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            m_desc_ready = desc_hold ? 1'b0 : (desc_rand ? ($urandom_range(0, 3) == 0) : 1'b1);
        end
    end

    initial begin : monitor
        bit           stall_prev;
        logic [559:0] held;
        ram_beat_t    rb;
        desc_t        d;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || ignore_mon) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("ram_hold", 560'({m_ram_valid, m_ram_addr, m_ram_data}), held);
                if (m_ram_valid && m_ram_ready) begin
                    if (ram_q.size() == 0) begin
                        fail_now("ram_extra_beat", int'(m_ram_addr));
                    end else begin
                        rb = ram_q.pop_front();
                        chk("ram_addr", 560'(m_ram_addr), 560'(rb.addr));
                        chk("ram_data", 560'(m_ram_data), 560'(rb.data));
                        chk("ram_rw", 560'(m_ram_rw), 560'(1));
                    end
                end
                stall_prev = m_ram_valid && !m_ram_ready;
                held = 560'({1'b1, m_ram_addr, m_ram_data});
                if (m_desc_valid) begin
                    chk("accept_during_desc", 560'(s_axis_pkt_ready), 560'(0));
                    if (m_desc_ready) begin
                        if (desc_q.size() == 0) begin
                            fail_now("desc_extra", int'(m_desc_addr));
                        end else begin
                            d = desc_q.pop_front();
                            chk("desc_addr", 560'(m_desc_addr), 560'(d.addr));
                            chk("desc_len", 560'(m_desc_len), 560'(d.len));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d queued", ram_q.size());
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rw_after_release", 560'(m_ram_rw), 560'(1));
        chk("ready_idle", 560'(s_axis_pkt_ready), 560'(0));

        // Release to a class that is already full.
        chk("ovf_init", 560'(free_ovf), 560'(0));
        free_pulse(2);
        @(negedge clk);
        chk("ovf_full_free", 560'(free_ovf), 560'(m_ovf));

        // Directed packets: single beat, class3 padding, drops, overlong and early-last.
        send_pkt(60, 1);
        send_pkt(300, 5);
        send_pkt(400, 7);
        drain();
        send_pkt(0, 2);
        send_pkt(600, 3);
        drain();
        chk("drop_cnt_directed", 560'(drop_cnt), 560'(m_drop));
        send_pkt(60, 3);
        send_pkt(200, 1);
        send_pkt(128, 2);
        send_pkt(512, 8);
        send_pkt(64, 1);
        drain();

        // Random traffic with back-pressure on both outputs.
        ram_rand  = 1'b1;
        desc_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(513, 1023)) :
                                                int'($urandom_range(1, 512));
            if ($urandom_range(0, 19) == 0) len = 0;
            send_pkt(len, int'($urandom_range(1, 9)));
        end
        drain();
        chk("drop_cnt_random", 560'(drop_cnt), 560'(m_drop));

        // A pending descriptor blocks the next packet.
        desc_hold = 1'b1;
        send_pkt(100, 2);
        fork
            send_pkt(150, 3);
        join_none
        repeat (40) @(negedge clk);
        chk("desc_held", 560'(m_desc_valid), 560'(1));
        chk("next_pkt_blocked", 560'(ram_q.size()), 560'(4));
        desc_hold = 1'b0;
        drain();

        // Exhaust class 1, then a stalled packet waits for one release.
        ram_rand  = 1'b0;
        desc_rand = 1'b0;
        while (m_cnt[1] > 0) send_pkt(100, 2);
        drain();
        fork
            send_pkt(100, 2);
        join_none
        repeat (30) @(negedge clk);
        chk("stall_no_ram", 560'(ram_q.size()), 560'(2));
        chk("stall_ready", 560'(s_axis_pkt_ready), 560'(0));
        chk("stall_addr_pending", 560'(ram_q[0].addr), 560'(16'h4000));
        @(posedge clk);
        #1;
        free_pulse(1);
        m_cnt[1]--;
        drain();

        // Reset in the middle of a packet write.
        ignore_mon = 1'b1;
        s_axis_pkt_len   = 10'd300;
        s_axis_pkt_data  = rand_beat();
        s_axis_pkt_last  = 1'b0;
        s_axis_pkt_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!s_axis_pkt_ready && w < 100);
        if (!s_axis_pkt_ready) fail_now("reach_write", w);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        s_axis_pkt_valid = 1'b0;
        #1 check_reset_outputs("midpkt");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ignore_mon = 1'b0;
        @(posedge clk);
        #1;
        chk("rw_after_rst2", 560'(m_ram_rw), 560'(1));
        send_pkt(60, 1);
        send_pkt(100, 2);
        drain();
        chk("drop_cnt_after_rst", 560'(drop_cnt), 560'(m_drop));
        chk("ovf_after_rst", 560'(free_ovf), 560'(m_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
